// File: rtl/des_ui_pkg.sv
// Shared constants, FSM encoding and scan-code helpers for the PS/2 hex-entry UI.
package des_ui_pkg;

  localparam int unsigned FILT_LEN_DEF      = 4;
  localparam int unsigned FRAME_TIMEOUT_DEF = 50000;
  localparam int unsigned SCR_PULSE_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_CLR  = 8'h76;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } hex_key_t;

  // Set-2 make code to hex digit; hit=0 for anything that is not a hex key.
  function automatic hex_key_t hex_lookup(input logic [7:0] code);
    hex_key_t k;
    k.hit = 1'b1;
    k.nib = 4'h0;
    case (code)
      8'h45: k.nib = 4'h0;
      8'h16: k.nib = 4'h1;
      8'h1E: k.nib = 4'h2;
      8'h26: k.nib = 4'h3;
      8'h25: k.nib = 4'h4;
      8'h2E: k.nib = 4'h5;
      8'h36: k.nib = 4'h6;
      8'h3D: k.nib = 4'h7;
      8'h3E: k.nib = 4'h8;
      8'h46: k.nib = 4'h9;
      8'h1C: k.nib = 4'hA;
      8'h32: k.nib = 4'hB;
      8'h21: k.nib = 4'hC;
      8'h23: k.nib = 4'hD;
      8'h24: k.nib = 4'hE;
      8'h2B: k.nib = 4'hF;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

  // Bit offset of nibble slot n (slot 0 occupies [63:60]).
  function automatic logic [5:0] nib_shift(input logic [4:0] n);
    return 6'(60 - 4 * int'(n[3:0]));
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: input synchronizers, clock glitch filter and 11-bit frame FSM.
module ps2_rx
  import des_ui_pkg::*;
#(
  parameter int unsigned FILT_LEN      = FILT_LEN_DEF,
  parameter int unsigned FRAME_TIMEOUT = FRAME_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2ck,
  input  logic       ps2dt,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       err
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned TCW = $clog2(FRAME_TIMEOUT + 1);

  logic [1:0]     ck_sync, dt_sync;
  logic           filt, strobe;
  logic [FCW-1:0] fcnt;
  frame_state_t   state;
  logic [7:0]     shreg;
  logic [2:0]     bit_cnt;
  logic           par_ok;
  logic [TCW-1:0] tmo;
  logic           dt_s;

  assign dt_s = dt_sync[1];

  // Filtered clock only follows after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_sync <= '0;
      dt_sync <= '0;
      filt    <= 1'b0;
      fcnt    <= '0;
      strobe  <= 1'b0;
    end else begin
      ck_sync <= {ck_sync[0], ps2ck};
      dt_sync <= {dt_sync[0], ps2dt};
      strobe  <= 1'b0;
      if (ck_sync[1] == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILT_LEN - 1)) begin
        filt   <= ck_sync[1];
        fcnt   <= '0;
        strobe <= filt;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      tmo        <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err        <= 1'b0;
      if (state == ST_IDLE) begin
        tmo <= '0;
      end else if (!strobe) begin
        if (tmo == TCW'(FRAME_TIMEOUT - 1)) begin
          state <= ST_IDLE;
          err   <= 1'b1;
          tmo   <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
      if (strobe) begin
        tmo <= '0;
        case (state)
          ST_IDLE: if (!dt_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            shreg   <= {dt_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= ^{shreg, dt_s};
            state  <= ST_STOP;
          end
          ST_STOP: begin
            if (dt_s && par_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_hex_entry.sv
// Hex-string entry from a PS/2 keyboard: scan-code decode, 16-nibble buffer, LCD refresh pulse.
module ps2_hex_entry
  import des_ui_pkg::*;
#(
  parameter int unsigned FILT_LEN      = FILT_LEN_DEF,
  parameter int unsigned FRAME_TIMEOUT = FRAME_TIMEOUT_DEF,
  parameter int unsigned SCR_PULSE     = SCR_PULSE_DEF
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        ps2ck,
  input  logic        ps2dt,
  output logic [63:0] values,
  output logic [4:0]  nEntered,
  output logic        full,
  output logic        screenRST,
  output logic        key_err
);

  localparam int unsigned SCW = $clog2(SCR_PULSE + 1);

  logic [7:0]     rx_byte;
  logic           rx_valid, rx_err;
  logic           ext, brk;
  logic [SCW-1:0] scr_cnt;
  logic [63:0]    values_nx;
  logic [4:0]     n_nx;
  logic           edit;
  logic           is_prefix;
  hex_key_t       key;

  ps2_rx #(
    .FILT_LEN      (FILT_LEN),
    .FRAME_TIMEOUT (FRAME_TIMEOUT)
  ) u_rx (
    .clk        (CLOCK_50),
    .rst        (rst),
    .ps2ck      (ps2ck),
    .ps2dt      (ps2dt),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .err        (rx_err)
  );

  assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);

  // Edit decision; only a plain make code (no E0/F0 before it) can edit.
  always_comb begin
    key       = hex_lookup(rx_byte);
    values_nx = values;
    n_nx      = nEntered;
    edit      = 1'b0;
    if (rx_valid && !is_prefix && !ext && !brk) begin
      if (key.hit) begin
        if (nEntered < 5'd16) begin
          values_nx = values | (64'(key.nib) << nib_shift(nEntered));
          n_nx      = nEntered + 5'd1;
          edit      = 1'b1;
        end
      end else if (rx_byte == SC_BKSP) begin
        if (nEntered != 5'd0) begin
          values_nx = values & ~(64'hF << nib_shift(nEntered - 5'd1));
          n_nx      = nEntered - 5'd1;
          edit      = 1'b1;
        end
      end else if (rx_byte == SC_CLR) begin
        values_nx = '0;
        n_nx      = '0;
        edit      = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      values    <= '0;
      nEntered  <= '0;
      full      <= 1'b0;
      key_err   <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      screenRST <= 1'b0;
      scr_cnt   <= SCW'(SCR_PULSE);
    end else begin
      values   <= values_nx;
      nEntered <= n_nx;
      full     <= (n_nx == 5'd16);
      key_err  <= rx_err;
      if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      // Low-pulse counter; each edit restarts it.
      if (edit) begin
        screenRST <= 1'b0;
        scr_cnt   <= SCW'(SCR_PULSE - 1);
      end else if (scr_cnt != '0) begin
        screenRST <= 1'b0;
        scr_cnt   <= scr_cnt - 1'b1;
      end else begin
        screenRST <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_hex_entry;

  localparam int unsigned H     = 15;
  localparam int unsigned TMO   = 2000;
  localparam int unsigned PULSE = 16;

  logic        CLOCK_50 = 1'b0;
  logic        rst      = 1'b1;
  logic        ps2ck    = 1'b1;
  logic        ps2dt    = 1'b1;
  logic [63:0] values;
  logic [4:0]  nEntered;
  logic        full;
  logic        screenRST;
  logic        key_err;

  int n_cmp = 0, n_bad = 0;
  int falls = 0, err_cnt = 0, low_run = 0, last_run = 0;
  logic prev_scr = 1'b1;
  int f0, e0, lows;

  ps2_hex_entry #(
    .FILT_LEN      (4),
    .FRAME_TIMEOUT (TMO),
    .SCR_PULSE     (PULSE)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .ps2ck     (ps2ck),
    .ps2dt     (ps2dt),
    .values    (values),
    .nEntered  (nEntered),
    .full      (full),
    .screenRST (screenRST),
    .key_err   (key_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Pulse / error monitor on the inactive edge.
  always @(negedge CLOCK_50) begin
    if (prev_scr && !screenRST) falls++;
    if (!screenRST) low_run++;
    else if (low_run != 0) begin
      last_run = low_run;
      low_run  = 0;
    end
    prev_scr = screenRST;
    if (key_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2dt = b;
    repeat (H) @(negedge CLOCK_50);
    ps2ck = 1'b0;
    repeat (H) @(negedge CLOCK_50);
    ps2ck = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2dt = 1'b1;
    repeat (H) @(negedge CLOCK_50);
  endtask

  task automatic make(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic make_break(input logic [7:0] b);
    send_byte(b, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(b, 1'b0);
  endtask

  task automatic count_reset_low(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (screenRST) break;
      n++;
    end
  endtask

  initial begin
    logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    // Reset state and refresh pulse after release
    repeat (3) @(negedge CLOCK_50);
    check("rst_values", values, 64'h0);
    check("rst_n", 64'(nEntered), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_key_err", 64'(key_err), 64'd0);
    check("rst_scr", 64'(screenRST), 64'd0);
    rst = 1'b0;
    count_reset_low(lows);
    check("rst_pulse_len", 64'(lows), 64'(PULSE));
    repeat (20) @(negedge CLOCK_50);

    // "1","3","A" with make/break
    f0 = falls;
    make_break(8'h16);
    check("k1_values", values, 64'h1000_0000_0000_0000);
    check("edit_pulse_len", 64'(last_run), 64'(PULSE));
    make_break(8'h26);
    make_break(8'h1C);
    check("13A_values", values, 64'h13A0_0000_0000_0000);
    check("13A_n", 64'(nEntered), 64'd3);
    check("13A_pulses", 64'(falls - f0), 64'd3);
    check("13A_full", 64'(full), 64'd0);

    // Clear, fill 16 digits, then one more key is ignored
    make(8'h76);
    check("clr_values", values, 64'h0);
    check("clr_n", 64'(nEntered), 64'd0);
    for (int i = 0; i < 16; i++) make(hex_codes[i]);
    check("fill_values", values, 64'h0123_4567_89AB_CDEF);
    check("fill_n", 64'(nEntered), 64'd16);
    check("fill_full", 64'(full), 64'd1);
    f0 = falls;
    make(8'h2E);
    check("over_values", values, 64'h0123_4567_89AB_CDEF);
    check("over_n", 64'(nEntered), 64'd16);
    check("over_pulses", 64'(falls - f0), 64'd0);

    // Backspace behaviour
    make(8'h76);
    make(8'h2B);
    make(8'h2B);
    make(8'h66);
    check("bs_n", 64'(nEntered), 64'd1);
    check("bs_values", values, 64'hF000_0000_0000_0000);
    check("bs_full", 64'(full), 64'd0);
    f0 = falls;
    make(8'h66);
    make(8'h66);
    check("bs0_n", 64'(nEntered), 64'd0);
    check("bs0_values", values, 64'h0);
    check("bs0_pulses", 64'(falls - f0), 64'd1);

    // Clear on an already-empty buffer still pulses
    f0 = falls;
    make(8'h76);
    check("clr_empty_pulses", 64'(falls - f0), 64'd1);

    // Parity error, extended prefix, unmapped code
    f0 = falls;
    e0 = err_cnt;
    send_byte(8'h16, 1'b1);
    check("par_err", 64'(err_cnt - e0), 64'd1);
    check("par_values", values, 64'h0);
    check("par_n", 64'(nEntered), 64'd0);
    make(8'hE0);
    make(8'h16);
    make(8'h5A);
    check("ext_n", 64'(nEntered), 64'd0);
    check("ext_pulses", 64'(falls - f0), 64'd0);

    // Partial frame times out, next frame decodes normally
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2dt = 1'b1;
    repeat (TMO + 200) @(negedge CLOCK_50);
    check("tmo_err", 64'(err_cnt - e0), 64'd1);
    make(8'h1E);
    check("tmo_next_values", values, 64'h2000_0000_0000_0000);
    check("tmo_next_n", 64'(nEntered), 64'd1);
    check("tmo_no_extra_err", 64'(err_cnt - e0), 64'd1);

    // Reset in the middle of a frame
    make(8'h26);
    make(8'h25);
    make(8'h2E);
    make(8'h36);
    check("pre_rst_n", 64'(nEntered), 64'd5);
    check("pre_rst_values", values, 64'h2345_6000_0000_0000);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2dt = 1'b0;
    ps2ck = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b1;
    #1;
    check("mid_rst_values", values, 64'h0);
    check("mid_rst_n", 64'(nEntered), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    check("mid_rst_scr", 64'(screenRST), 64'd0);
    ps2ck = 1'b1;
    ps2dt = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    rst = 1'b0;
    count_reset_low(lows);
    check("mid_rst_pulse_len", 64'(lows), 64'(PULSE));
    f0 = falls;
    e0 = err_cnt;
    repeat (200) @(negedge CLOCK_50);
    check("post_rst_n", 64'(nEntered), 64'd0);
    check("post_rst_values", values, 64'h0);
    check("post_rst_no_edit", 64'(falls - f0), 64'd0);
    make(8'h24);
    check("post_rst_key", values, 64'hE000_0000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
